// File: rtl/fetch_controller.sv
// fetch_controller: single-outstanding instruction fetch FSM with redirect and stall handling.
// Optional misaligned-redirect checking is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_controller #(
  parameter int PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                stall,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic [PC_WIDTH-1:0] pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                misalign_err
`endif
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2, DRAIN = 2'd3;
  logic [1:0] state;
  logic redir;
`ifdef FETCH_MISALIGN_CHECK_EN
  // a misaligned target is dropped entirely and only flagged
  assign redir = redirect_valid && redirect_pc[1:0] == 2'b00;
  always_ff @(posedge clk)
    if (rst) misalign_err <= 1'b0;
    else if (redirect_valid && redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
`else
  assign redir = redirect_valid;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          imem_req  <= 1'b1;
          imem_addr <= redir ? redirect_pc : pc;
          pc        <= redir ? redirect_pc : pc;
          state     <= WAIT;
        end
        WAIT:
          if (redir) begin
            pc <= redirect_pc;
            imem_req <= !imem_ack;
            state <= imem_ack ? IDLE : DRAIN;
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= imem_addr;
            instr_valid <= 1'b1;
            pc          <= pc + PC_WIDTH'(4);
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        DRAIN: begin
          if (redir) pc <= redirect_pc;
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        HOLD:
          if (redir) begin
            instr_valid <= 1'b0;
            pc          <= redirect_pc;
            state       <= IDLE;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            imem_addr   <= pc;
            imem_req    <= 1'b1;
            state       <= WAIT;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 16, program counter and instruction address width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0, fetch address loaded on reset; low 2 bits are zero.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port redirect_valid  input  1  branch or jump taken; redirect_pc is valid this cycle.
REQ-006 SHALL have port redirect_pc  input  PC_WIDTH  new fetch address.
REQ-007 SHALL have port stall  input  1  consumer not ready; the held instruction is not accepted.
REQ-008 SHALL have port imem_req  output  1  instruction memory request, registered.
REQ-009 SHALL have port imem_addr  output  PC_WIDTH  request address, registered, stable while imem_req is high.
REQ-010 SHALL have port imem_ack  input  1  single-cycle response strobe; imem_rdata is valid this cycle.
REQ-011 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-012 SHALL have port instr_valid  output  1  instr and instr_pc are valid.
REQ-013 SHALL have port instr  output  32  fetched instruction.
REQ-014 SHALL have port instr_pc  output  PC_WIDTH  address of instr.
REQ-015 SHALL have port pc  output  PC_WIDTH  next address to be fetched.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, HOLD and DRAIN, with at most one memory request outstanding.
REQ-017 IDLE SHALL go to WAIT on the next cycle and latch imem_addr<=pc and imem_req<=1; redirect in IDLE SHALL load pc<=redirect_pc first, so the new address is fetched.
REQ-018 WAIT SHALL hold imem_req=1 and imem_addr until imem_ack.
- On ack without redirect: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, pc<=pc+4, imem_req<=0, then HOLD.
REQ-019 WAIT with redirect_valid SHALL load pc<=redirect_pc.
- Ack in the same cycle: the response is discarded and the next state is IDLE.
- No ack: the next state is DRAIN.
REQ-020 DRAIN SHALL keep imem_req=1 with the old imem_addr until imem_ack, discard that response and go to IDLE; a further redirect in DRAIN SHALL update pc and stay in DRAIN.
REQ-021 HOLD SHALL keep instr_valid=1 with instr and instr_pc stable while stall=1.
- stall=0 is acceptance; the next state is WAIT with imem_addr<=pc and imem_req<=1 registered.
REQ-022 redirect_valid in HOLD SHALL squash the held instruction: instr_valid<=0, pc<=redirect_pc, then IDLE, regardless of stall.
REQ-023 Redirect SHALL have priority over imem_ack and stall in every state.
REQ-024 pc+4 SHALL wrap modulo 2^PC_WIDTH; for PC_WIDTH=16, 0xFFFC increments to 0x0000.
REQ-025 instr_valid SHALL be 1 only in HOLD, and each accepted instruction SHALL be presented exactly once.
REQ-026 imem_ack outside WAIT and DRAIN SHALL be ignored.

Reset
REQ-027 rst=1 at a clock edge SHALL set the state to IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, instr_valid=0, instr=0 and instr_pc=0, overriding all other inputs.
REQ-028 Reset during WAIT or DRAIN SHALL abandon the outstanding request, and an ack in the cycle after reset SHALL be ignored.

Configuration
REQ-029 The macro FETCH_MISALIGN_CHECK_EN SHALL control misaligned-redirect checking.
- Defined: adds output misalign_err (1 bit, reset 0). A redirect whose redirect_pc[1:0]!=0 is ignored (no state, pc or squash effect) and sets misalign_err sticky until rst.
- Undefined: no misalign_err port; redirect_pc is used as given.

Verification
REQ-030 Reset then continuous fetch: RESET_PC=0x0000, ack 2 cycles after each req, stall=0 -> instr_pc sequence 0x0000, 0x0004, 0x0008, each instr equals the returned rdata.
REQ-031 Stall hold: instr_valid with instr_pc=0x0004 and stall=1 for 3 cycles -> instr and instr_pc stable, imem_req=0; next req at 0x0008 one cycle after stall falls.
REQ-032 Redirect during WAIT: req at 0x0010 outstanding, redirect to 0x0100, ack 2 cycles later with 0xDEADBEEF -> that word is never presented; next imem_addr=0x0100.
REQ-033 Redirect in HOLD with stall=1 -> instr_valid=0 next cycle; next fetch at the redirect_pc value.
REQ-034 Wrap: redirect to 0xFFFC, ack -> instr_pc=0xFFFC, next imem_addr=0x0000.
REQ-035 Misalign (macro defined): redirect_pc=0x0102 -> misalign_err=1 next cycle, fetch sequence unchanged; (macro undefined) -> imem_addr=0x0102.
